// File: rtl/fetch_branch_unit.sv
// LEGv8 front end: program counter, IF/ID pipeline register and N/Z/V/C flags,
// with branch resolution in ID (B, BL, BR, B.LT, CBZ) and one squashed slot per taken branch.
module fetch_branch_unit #(
  parameter int              PC_W     = 64,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  output logic [PC_W-1:0] imem_addr,
  input  logic [31:0]     imem_data,
  input  logic            stall,
  output logic [31:0]     if_id_instr,
  output logic [PC_W-1:0] if_id_pc,
  output logic            if_id_valid,
  output logic [10:0]     opcode,
  input  logic            uncond_branch,
  input  logic            cond_branch,
  input  logic            check_for_lt,
  input  logic            branch_register,
  input  logic [PC_W-1:0] reg_target,
  input  logic            cbz_zero,
  input  logic            flags_we,
  input  logic [3:0]      flags_in,
  output logic [3:0]      flags,
  output logic            redirect,
  output logic [PC_W-1:0] link_addr
);

  localparam logic [PC_W-1:0] PC_STEP = {{(PC_W-3){1'b0}}, 3'd4};

  logic [PC_W-1:0] pc_q, pc_d;
  logic [31:0]     if_instr_q, if_instr_d;
  logic [PC_W-1:0] if_pc_q, if_pc_d;
  logic            if_valid_q, if_valid_d;
  logic [3:0]      flags_q, flags_d;

  logic [3:0]      eff_flags_s;
  logic            cond_ok_s;
  logic            take_s;
  logic [25:0]     imm26_s;
  logic [18:0]     imm19_s;
  logic [PC_W-1:0] offset_s;
  logic [PC_W-1:0] target_s;

  assign imm26_s = if_instr_q[25:0];
  assign imm19_s = if_instr_q[23:5];

  // Branch decision and target; flags are bypassed so B.LT right behind SUBS sees its result.
  always_comb begin
    eff_flags_s = flags_q;
    cond_ok_s   = 1'b0;
    offset_s    = '0;
    target_s    = '0;
    take_s      = 1'b0;

    if (flags_we) begin
      eff_flags_s = flags_in;
    end else begin
      eff_flags_s = flags_q;
    end

    if (check_for_lt) begin
      cond_ok_s = eff_flags_s[3] ^ eff_flags_s[1];
    end else begin
      cond_ok_s = cbz_zero;
    end

    if (uncond_branch) begin
      offset_s = {{(PC_W-28){imm26_s[25]}}, imm26_s, 2'b00};
    end else begin
      offset_s = {{(PC_W-21){imm19_s[18]}}, imm19_s, 2'b00};
    end

    if (branch_register) begin
      target_s = reg_target;
    end else begin
      target_s = if_pc_q + offset_s;
    end

    take_s = if_valid_q & ~stall & (uncond_branch | (cond_branch & cond_ok_s));
  end

  // Next-state selection: stall freezes everything, a taken branch squashes the wrong-path fetch.
  always_comb begin
    pc_d       = pc_q;
    if_instr_d = if_instr_q;
    if_pc_d    = if_pc_q;
    if_valid_d = if_valid_q;
    flags_d    = flags_q;

    if (stall) begin
      pc_d       = pc_q;
      if_instr_d = if_instr_q;
      if_pc_d    = if_pc_q;
      if_valid_d = if_valid_q;
    end else if (take_s) begin
      pc_d       = target_s;
      if_instr_d = 32'd0;
      if_pc_d    = pc_q;
      if_valid_d = 1'b0;
    end else begin
      pc_d       = pc_q + PC_STEP;
      if_instr_d = imem_data;
      if_pc_d    = pc_q;
      if_valid_d = 1'b1;
    end

    if (flags_we && !stall) begin
      flags_d = flags_in;
    end else begin
      flags_d = flags_q;
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q       <= RESET_PC;
      if_instr_q <= 32'd0;
      if_pc_q    <= '0;
      if_valid_q <= 1'b0;
      flags_q    <= 4'd0;
    end else begin
      pc_q       <= pc_d;
      if_instr_q <= if_instr_d;
      if_pc_q    <= if_pc_d;
      if_valid_q <= if_valid_d;
      flags_q    <= flags_d;
    end
  end

  assign imem_addr   = pc_q;
  assign if_id_instr = if_instr_q;
  assign if_id_pc    = if_pc_q;
  assign if_id_valid = if_valid_q;
  assign opcode      = if_instr_q[31:21];
  assign flags       = flags_q;
  assign redirect    = take_s;
  assign link_addr   = if_pc_q + PC_STEP;

endmodule

// File: tb/tb_fetch_branch_unit.sv
// Directed bench for fetch_branch_unit: a small instruction memory and control decoder
// drive a program through B, BL, BR, B.LT and CBZ; predictions go through a scoreboard queue.
module tb_fetch_branch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] imem_addr;
  logic [31:0] imem_data;
  logic        stall;
  logic [31:0] if_id_instr;
  logic [63:0] if_id_pc;
  logic        if_id_valid;
  logic [10:0] opcode;
  logic        uncond_branch, cond_branch, check_for_lt, branch_register;
  logic [63:0] reg_target;
  logic        cbz_zero;
  logic        flags_we;
  logic [3:0]  flags_in;
  logic [3:0]  flags;
  logic        redirect;
  logic [63:0] link_addr;

  fetch_branch_unit #(.PC_W(64), .RESET_PC(64'd0)) dut (
    .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_data(imem_data),
    .stall(stall), .if_id_instr(if_id_instr), .if_id_pc(if_id_pc),
    .if_id_valid(if_id_valid), .opcode(opcode), .uncond_branch(uncond_branch),
    .cond_branch(cond_branch), .check_for_lt(check_for_lt),
    .branch_register(branch_register), .reg_target(reg_target), .cbz_zero(cbz_zero),
    .flags_we(flags_we), .flags_in(flags_in), .flags(flags), .redirect(redirect),
    .link_addr(link_addr)
  );

  always #5 clk = ~clk;

  localparam logic [31:0] ADDI = 32'h91000421;

  logic [31:0] mem [0:1023];
  assign imem_data = mem[imem_addr[11:2]];

  // Reference control decoder driven by the opcode in ID.
  always_comb begin
    uncond_branch   = (opcode[10:5] == 6'b000101) || (opcode[10:5] == 6'b100101) ||
                      (opcode == 11'h6B0);
    cond_branch     = (opcode[10:3] == 8'h54) || (opcode[10:3] == 8'hB4);
    check_for_lt    = (opcode[10:3] == 8'h54);
    branch_register = (opcode == 11'h6B0);
  end

  typedef struct {
    string       tag;
    logic [63:0] val;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic push(input string t, input logic [63:0] v);
    exp_t e;
    e.tag = t;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic pop_chk(input logic [63:0] obs);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty observed=%0h expected=entry", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        errors++;
        $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic now(input string t, input logic [63:0] v, input logic [63:0] obs);
    push(t, v);
    pop_chk(obs);
  endtask

  // Predict post-edge state, advance one clock, then compare.
  task automatic step(input logic [63:0] pc, input logic v, input logic [63:0] ipc);
    push("imem_addr", pc);
    push("if_id_valid", {63'd0, v});
    push("if_id_pc", ipc);
    @(posedge clk);
    #1;
    pop_chk(imem_addr);
    pop_chk({63'd0, if_id_valid});
    pop_chk(if_id_pc);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = ADDI;
    mem[32'h008 >> 2] = {6'b000101, 26'd3};           // B +3     -> 0x14
    mem[32'h014 >> 2] = {6'b000101, 26'd11};          // B +11    -> 0x40
    mem[32'h040 >> 2] = {6'b000101, 26'h3FFFFFE};     // B -2     -> 0x38
    mem[32'h03C >> 2] = {8'h54, 19'h31, 1'b0, 4'hB};  // B.LT     -> 0x100
    mem[32'h100 >> 2] = {6'b100101, 26'h40};          // BL       -> 0x200
    mem[32'h204 >> 2] = {8'h54, 19'h10, 1'b0, 4'hB};  // B.LT (not taken)
    mem[32'h208 >> 2] = {8'hB4, 19'h10, 5'd1};        // CBZ (not taken)
    mem[32'h20C >> 2] = {6'b000101, 26'h3FFFF85};     // B        -> 0x20
    mem[32'h020 >> 2] = {8'hB4, 19'h7FFFE, 5'd1};     // CBZ -2   -> 0x18
    mem[32'h01C >> 2] = 32'hD61F0060;                 // BR X3

    reset = 1'b1; stall = 1'b0; cbz_zero = 1'b0; flags_we = 1'b0;
    flags_in = 4'd0; reg_target = 64'd0;
    #2;
    now("rst_imem_addr", 64'd0, imem_addr);
    now("rst_valid", 64'd0, {63'd0, if_id_valid});
    now("rst_instr", 64'd0, {32'd0, if_id_instr});
    now("rst_if_pc", 64'd0, if_id_pc);
    now("rst_flags", 64'd0, {60'd0, flags});
    @(negedge clk);
    reset = 1'b0;
    #1 now("redirect_empty_slot", 64'd0, {63'd0, redirect});

    step(64'h4, 1'b1, 64'h0);
    #1 now("redirect_addi", 64'd0, {63'd0, redirect});
    step(64'h8, 1'b1, 64'h4);
    step(64'hC, 1'b1, 64'h8);
    #1 now("b_instr", {32'd0, 6'b000101, 26'd3}, {32'd0, if_id_instr});
    now("b_redirect", 64'd1, {63'd0, redirect});
    step(64'h14, 1'b0, 64'hC);
    #1 now("squash_opcode", 64'd0, {53'd0, opcode});
    now("squash_redirect", 64'd0, {63'd0, redirect});
    step(64'h18, 1'b1, 64'h14);
    step(64'h40, 1'b0, 64'h18);
    step(64'h44, 1'b1, 64'h40);
    #1 now("b_neg_redirect", 64'd1, {63'd0, redirect});
    step(64'h38, 1'b0, 64'h44);
    step(64'h3C, 1'b1, 64'h38);
    step(64'h40, 1'b1, 64'h3C);
    flags_we = 1'b1; flags_in = 4'b1000;
    #1 now("blt_bypass_redirect", 64'd1, {63'd0, redirect});
    now("flags_before_write", 64'd0, {60'd0, flags});
    step(64'h100, 1'b0, 64'h40);
    flags_we = 1'b0;
    #1 now("flags_written", 64'h8, {60'd0, flags});
    step(64'h104, 1'b1, 64'h100);
    #1 now("bl_link_addr", 64'h104, link_addr);
    now("bl_redirect", 64'd1, {63'd0, redirect});
    step(64'h200, 1'b0, 64'h104);
    step(64'h204, 1'b1, 64'h200);
    step(64'h208, 1'b1, 64'h204);
    flags_we = 1'b1; flags_in = 4'b1010;
    #1 now("blt_not_taken", 64'd0, {63'd0, redirect});
    step(64'h20C, 1'b1, 64'h208);
    flags_we = 1'b0; cbz_zero = 1'b0;
    #1 now("cbz_not_taken", 64'd0, {63'd0, redirect});
    now("flags_nv", 64'hA, {60'd0, flags});
    step(64'h210, 1'b1, 64'h20C);
    step(64'h20, 1'b0, 64'h210);
    step(64'h24, 1'b1, 64'h20);
    cbz_zero = 1'b1;
    #1 now("cbz_taken", 64'd1, {63'd0, redirect});
    step(64'h18, 1'b0, 64'h24);
    cbz_zero = 1'b0;
    step(64'h1C, 1'b1, 64'h18);
    step(64'h20, 1'b1, 64'h1C);
    stall = 1'b1; reg_target = 64'h1234; flags_we = 1'b1; flags_in = 4'b0101;
    #1 now("br_stall_redirect", 64'd0, {63'd0, redirect});
    step(64'h20, 1'b1, 64'h1C);
    #1 now("stall_flags_hold", 64'hA, {60'd0, flags});
    now("stall_redirect_2", 64'd0, {63'd0, redirect});
    step(64'h20, 1'b1, 64'h1C);
    stall = 1'b0; flags_we = 1'b0;
    #1 now("br_release_redirect", 64'd1, {63'd0, redirect});
    step(64'h1234, 1'b0, 64'h20);
    step(64'h1238, 1'b1, 64'h1234);
    stall = 1'b1;
    #2 reset = 1'b1;
    #1 now("async_rst_pc", 64'd0, imem_addr);
    now("async_rst_valid", 64'd0, {63'd0, if_id_valid});
    now("async_rst_if_pc", 64'd0, if_id_pc);
    now("async_rst_flags", 64'd0, {60'd0, flags});
    @(negedge clk);
    reset = 1'b0; stall = 1'b0;
    step(64'h4, 1'b1, 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
